x_switch: RTL and testbench

- 4x4 packet crossbar. Each of 4 source ports writes an {address, data} word. The word is routed to the destination port whose programmed address matches, and is queued in that destination's FIFO.
- Destinations drain their FIFOs with rd_en and expose per-FIFO status flags.
- Priority and port-address registers are programmable at run time.
- Sits between traffic sources and sinks as the switching core of the top-level wrapper.

---
 rtl/x_switch.sv | 195 +++++++++++++++++++
 tb/tb_x_switch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_switch.sv
`default_nettype none
// ============================================================================
//  Module      : x_switch
//  Description : 4x4 packet crossbar. Address-matched routing, rotating-start
//                arbitration per destination, FWFT destination FIFOs.
//                Optional macro XSWITCH_RR_ARB_EN enables round-robin priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module x_switch #(
    parameter int N      = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int DEPTH  = 8,
    parameter int AE_LVL = 2,
    parameter int AF_LVL = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*AW-1:0]       addr_in,
    input  logic [N*DW-1:0]       data_in,
    input  logic [N-1:0]          wr_en,
    output logic [N-1:0]          data_rcv,
    output logic [N*AW-1:0]       addr_out,
    output logic [N*DW-1:0]       data_out,
    input  logic [N-1:0]          rd_en,
    output logic [N-1:0]          data_rdy,
    output logic [N-1:0]          fifo_empty,
    output logic [N-1:0]          fifo_ae,
    output logic [N-1:0]          fifo_af,
    output logic [N-1:0]          fifo_full,
    input  logic                  prio_wr,
    input  logic [1:0]            prio_val,
    input  logic [N-1:0]          port_en,
    input  logic                  port_wr,
    input  logic [1:0]            port_sel,
    input  logic [AW-1:0]         port_addr
);

    localparam int IW = 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = AW + DW;

    logic [AW-1:0]  r_paddr [N];
    logic [IW-1:0]  r_prio;
    logic [N-1:0]   r_rcv;

    logic [N-1:0]   w_hit;
    logic [IW-1:0]  w_dst   [N];
    logic [N-1:0]   w_push;
    logic [N-1:0]   w_pop;
    logic [N-1:0]   w_gnt;
    logic [IW-1:0]  w_win   [N];
    logic [EW-1:0]  w_wdata [N];
    logic [IW-1:0]  w_s;
    logic [N-1:0]   w_full;
    logic [N-1:0]   w_empty;

    // Lowest-index port whose address register matches wins the route.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_hit[i] = 1'b0;
            w_dst[i] = '0;
            for (int j = N - 1; j >= 0; j--) begin
                if (r_paddr[j] == addr_in[i*AW +: AW]) begin
                    w_hit[i] = 1'b1;
                    w_dst[i] = IW'(j);
                end
            end
        end
    end

    // Per destination: scan sources from r_prio upward; descending loop so the
    // nearest candidate in search order is the last assignment.
    always_comb begin
        w_push = '0;
        w_gnt  = '0;
        w_s    = '0;
        for (int j = 0; j < N; j++) begin
            w_win[j]   = '0;
            w_wdata[j] = '0;
            for (int k = N - 1; k >= 0; k--) begin
                w_s = r_prio + IW'(k);
                if (wr_en[w_s] && w_hit[w_s] && (w_dst[w_s] == IW'(j)) &&
                    port_en[j] && !w_full[j]) begin
                    w_push[j] = 1'b1;
                    w_win[j]  = w_s;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (w_win[j] == IW'(i)) begin
                    w_wdata[j] = {r_paddr[i], data_in[i*DW +: DW]};
                end
            end
            if (w_push[j]) begin
                w_gnt[w_win[j]] = 1'b1;
            end
        end
    end

`ifdef XSWITCH_RR_ARB_EN
    logic          w_rr_any;
    logic [IW-1:0] w_rr_next;
    logic [IW-1:0] w_rr_t;

    always_comb begin
        w_rr_any  = 1'b0;
        w_rr_next = r_prio;
        w_rr_t    = '0;
        for (int k = 0; k < N; k++) begin
            w_rr_t = r_prio + IW'(k);
            if (w_gnt[w_rr_t]) begin
                w_rr_any  = 1'b1;
                w_rr_next = w_rr_t + IW'(1);
            end
        end
    end
`endif

    assign w_pop    = rd_en & ~w_empty;
    assign data_rcv = r_rcv;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prio <= '0;
            r_rcv  <= '0;
            for (int j = 0; j < N; j++) begin
                r_paddr[j] <= AW'(j);
            end
        end else begin
            r_rcv <= w_gnt;
            if (prio_wr) begin
                r_prio <= prio_val;
            end
`ifdef XSWITCH_RR_ARB_EN
            else if (w_rr_any) begin
                r_prio <= w_rr_next;
            end
`endif
            if (port_wr) begin
                r_paddr[port_sel] <= port_addr;
            end
        end
    end

    generate
        for (genvar j = 0; j < N; j++) begin : g_fifo
            logic [EW-1:0] r_mem [DEPTH];
            logic [PW-1:0] r_wptr;
            logic [PW-1:0] r_rptr;
            logic [CW-1:0] r_cnt;
            logic [EW-1:0] w_head;

            // Storage is not reset; the count alone decides what is valid.
            always_ff @(posedge clk) begin
                if (w_push[j]) begin
                    r_mem[r_wptr] <= w_wdata[j];
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push[j]) begin
                        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
                    end
                    if (w_pop[j]) begin
                        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
                    end
                    case ({w_push[j], w_pop[j]})
                        2'b10:   r_cnt <= r_cnt + CW'(1);
                        2'b01:   r_cnt <= r_cnt - CW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            assign w_head        = r_mem[r_rptr];
            assign w_empty[j]    = (r_cnt == '0);
            assign w_full[j]     = (r_cnt == CW'(DEPTH));
            assign fifo_empty[j] = w_empty[j];
            assign fifo_full[j]  = w_full[j];
            assign fifo_ae[j]    = (r_cnt <= CW'(AE_LVL));
            assign fifo_af[j]    = (r_cnt >= CW'(AF_LVL));
            assign data_rdy[j]   = ~w_empty[j];
            assign data_out[j*DW +: DW] = w_empty[j] ? '0 : w_head[DW-1:0];
            assign addr_out[j*AW +: AW] = w_empty[j] ? '0 : w_head[EW-1:DW];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_x_switch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_x_switch
//  Description : Directed bench for x_switch with a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_x_switch;

    localparam int N      = 4;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int AE_LVL = 2;
    localparam int AF_LVL = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*AW-1:0] addr_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    wr_en;
    logic [N-1:0]    data_rcv;
    logic [N*AW-1:0] addr_out;
    logic [N*DW-1:0] data_out;
    logic [N-1:0]    rd_en;
    logic [N-1:0]    data_rdy;
    logic [N-1:0]    fifo_empty, fifo_ae, fifo_af, fifo_full;
    logic            prio_wr;
    logic [1:0]      prio_val;
    logic [N-1:0]    port_en;
    logic            port_wr;
    logic [1:0]      port_sel;
    logic [AW-1:0]   port_addr;

    always #5 clk = ~clk;

    x_switch #(.N(N), .AW(AW), .DW(DW), .DEPTH(DEPTH), .AE_LVL(AE_LVL), .AF_LVL(AF_LVL)) dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
        .data_rcv(data_rcv), .addr_out(addr_out), .data_out(data_out), .rd_en(rd_en),
        .data_rdy(data_rdy), .fifo_empty(fifo_empty), .fifo_ae(fifo_ae), .fifo_af(fifo_af),
        .fifo_full(fifo_full), .prio_wr(prio_wr), .prio_val(prio_val), .port_en(port_en),
        .port_wr(port_wr), .port_sel(port_sel), .port_addr(port_addr)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [AW+DW-1:0] mq [N][$];
    logic [AW-1:0]    m_addr [N];
    logic [1:0]       m_prio;
    logic [N-1:0]     m_rcv;
    logic [N-1:0]     m_nrcv;
    int               m_dst [N];
    int               m_sz  [N];
    int               m_s;
    int               m_last;

    always @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < N; j++) begin
                mq[j].delete();
                m_addr[j] = AW'(j);
            end
            m_prio = 2'd0;
            m_rcv  = '0;
        end else begin
            m_nrcv = '0;
            m_last = -1;
            for (int i = 0; i < N; i++) begin
                m_dst[i] = -1;
                if (wr_en[i])
                    for (int j = N - 1; j >= 0; j--)
                        if (m_addr[j] == addr_in[i*AW +: AW]) m_dst[i] = j;
            end
            for (int j = 0; j < N; j++) m_sz[j] = mq[j].size();
            for (int j = 0; j < N; j++) begin
                if (port_en[j] && m_sz[j] < DEPTH) begin
                    for (int k = 0; k < N; k++) begin
                        m_s = (int'(m_prio) + k) % N;
                        if (m_dst[m_s] == j) begin
                            mq[j].push_back({m_addr[m_s], data_in[m_s*DW +: DW]});
                            m_nrcv[m_s] = 1'b1;
                            break;
                        end
                    end
                end
            end
            for (int j = 0; j < N; j++)
                if (rd_en[j] && m_sz[j] > 0) void'(mq[j].pop_front());
            for (int k = 0; k < N; k++) begin
                m_s = (int'(m_prio) + k) % N;
                if (m_nrcv[m_s]) m_last = m_s;
            end
            if (prio_wr) m_prio = prio_val;
`ifdef XSWITCH_RR_ARB_EN
            else if (m_last >= 0) m_prio = 2'((m_last + 1) % N);
`endif
            if (port_wr) m_addr[port_sel] = port_addr;
            m_rcv = m_nrcv;
        end
    end

    // ---------------- per-cycle comparison ----------------
    int               c_sz;
    logic [AW+DW-1:0] c_hd;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_rcv", 64'(data_rcv), 64'(m_rcv));
            for (int j = 0; j < N; j++) begin
                c_sz = mq[j].size();
                c_hd = (c_sz != 0) ? mq[j][0] : '0;
                chk($sformatf("port%0d_state", j),
                    64'({data_rdy[j], fifo_empty[j], fifo_ae[j], fifo_af[j], fifo_full[j],
                         addr_out[j*AW +: AW], data_out[j*DW +: DW]}),
                    64'({c_sz != 0, c_sz == 0, c_sz <= AE_LVL, c_sz >= AF_LVL, c_sz == DEPTH, c_hd}));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input int src, input logic [7:0] a, input logic [7:0] d, output logic got);
        addr_in[src*AW +: AW] = a;
        data_in[src*DW +: DW] = d;
        wr_en[src] = 1'b1;
        tick();
        wr_en[src] = 1'b0;
        got = data_rcv[src];
    endtask

    logic       got;
    logic [1:0] ord [3];
    int         nord;

    initial begin
        reset = 1'b0; addr_in = '0; data_in = '0; wr_en = '0; rd_en = '0;
        prio_wr = 1'b0; prio_val = '0; port_en = 4'hF; port_wr = 1'b0;
        port_sel = '0; port_addr = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_empty", 64'(fifo_empty), 64'h0F);
        chk("rst_ae",    64'(fifo_ae),    64'h0F);
        chk("rst_af",    64'({fifo_af, fifo_full, data_rdy}), 64'h0);
        chk("rst_rcv",   64'(data_rcv),   64'h0);
        chk("rst_dout",  64'({addr_out, data_out}), 64'h0);
        reset = 1'b1;
        tick();

        // basic route
        push1(0, 8'h02, 8'hA5, got);
        chk("t1_rcv",  64'(got), 64'h1);
        chk("t1_rdy2", 64'(data_rdy[2]), 64'h1);
        chk("t1_dout", 64'(data_out[23:16]), 64'hA5);
        chk("t1_aout", 64'(addr_out[23:16]), 64'h00);
        tick();
        chk("t1_pulse", 64'(data_rcv), 64'h0);
        rd_en[2] = 1'b1; tick(); rd_en = '0;
        chk("t1_empty", 64'(fifo_empty[2]), 64'h1);

        // port address programming and unmatched address
        port_wr = 1'b1; port_sel = 2'd1; port_addr = 8'h55; tick(); port_wr = 1'b0;
        push1(3, 8'h55, 8'h3C, got);
        chk("t2_rcv",  64'(got), 64'h1);
        chk("t2_dout", 64'(data_out[15:8]), 64'h3C);
        chk("t2_aout", 64'(addr_out[15:8]), 64'h03);
        addr_in[31:24] = 8'h01; wr_en[3] = 1'b1;
        tick(); chk("t2_nomatch_a", 64'(data_rcv), 64'h0);
        tick(); chk("t2_nomatch_b", 64'(data_rcv), 64'h0);
        wr_en = '0;
        rd_en[1] = 1'b1; tick(); rd_en = '0;

        // fixed-priority contention on port 0
        prio_val = 2'd2; prio_wr = 1'b1; tick(); prio_wr = 1'b0;
        addr_in[7:0] = 8'h00; addr_in[15:8] = 8'h00; addr_in[23:16] = 8'h00;
        data_in[7:0] = 8'h10; data_in[15:8] = 8'h11; data_in[23:16] = 8'h12;
        wr_en = 4'b0111;
        nord = 0;
        for (int q = 0; q < 3; q++) ord[q] = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (data_rcv[i]) begin
                    if (nord < 3) ord[nord] = 2'(i);
                    nord++;
                    wr_en[i] = 1'b0;
                end
            end
        end
        wr_en = '0;
        chk("t3_count", 64'(nord), 64'd3);
        chk("t3_order", 64'({ord[0], ord[1], ord[2]}), 64'b10_00_01);
        chk("t3_head",  64'({addr_out[7:0], data_out[7:0]}), 64'h0212);
        rd_en[0] = 1'b1; tick(); tick(); tick(); rd_en = '0;

        // fill port 3 and check the level flags
        for (int k = 0; k < DEPTH; k++) begin
            push1(1, 8'h03, 8'(8'h30 + k), got);
            chk($sformatf("t4_rcv%0d", k), 64'(got), 64'h1);
            chk($sformatf("t4_flags%0d", k), 64'({fifo_ae[3], fifo_af[3], fifo_full[3]}),
                64'({(k + 1) <= AE_LVL, (k + 1) >= AF_LVL, (k + 1) == DEPTH}));
        end
        push1(1, 8'h03, 8'h38, got);
        chk("t4_ninth_blocked", 64'(got), 64'h0);
        wr_en[1] = 1'b1; rd_en[3] = 1'b1;
        tick(); rd_en = '0;
        chk("t4_full_pop_blocks", 64'({data_rcv[1], fifo_full[3]}), 64'b00);
        tick(); wr_en = '0;
        chk("t4_after_pop", 64'({data_rcv[1], fifo_full[3]}), 64'b11);
        chk("t4_head", 64'(data_out[31:24]), 64'h31);
        rd_en[3] = 1'b1;
        for (int k = 0; k < DEPTH; k++) tick();
        rd_en = '0;
        chk("t4_drained", 64'(fifo_empty[3]), 64'h1);

        // parallel grants plus simultaneous push/pop
        push1(2, 8'h02, 8'h77, got);
        addr_in[7:0] = 8'h00; data_in[7:0] = 8'h88;
        addr_in[23:16] = 8'h02; data_in[23:16] = 8'h99;
        wr_en = 4'b0101; rd_en[2] = 1'b1;
        tick(); wr_en = '0; rd_en = '0;
        chk("t5_rcv", 64'(data_rcv), 64'b0101);
        chk("t5_heads", 64'({data_out[23:16], data_out[7:0], fifo_empty[2]}), 64'({8'h99, 8'h88, 1'b0}));
        rd_en = 4'b0101; tick(); rd_en = '0;

        // disabled port still drains
        for (int k = 0; k < 3; k++) push1(0, 8'h55, 8'(8'h41 + k), got);
        port_en[1] = 1'b0;
        push1(0, 8'h55, 8'h44, got);
        chk("t6_disabled", 64'(got), 64'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_drain%0d", k), 64'(data_out[15:8]), 64'(8'h41 + k));
            rd_en[1] = 1'b1; tick(); rd_en = '0;
        end
        rd_en[1] = 1'b1; tick(); rd_en = '0;
        chk("t6_underflow", 64'({fifo_empty[1], fifo_full[1]}), 64'b10);
        port_en = 4'hF;

        // reset with data queued
        push1(2, 8'h02, 8'hC1, got);
        push1(3, 8'h03, 8'hC2, got);
        addr_in[7:0] = 8'h02; wr_en[0] = 1'b1;
        reset = 1'b0;
        tick();
        wr_en = '0;
        chk("t7_empty", 64'(fifo_empty), 64'h0F);
        chk("t7_rcv",   64'(data_rcv),   64'h0);
        reset = 1'b1;
        tick();
        push1(0, 8'h01, 8'h5A, got);
        chk("t7_addr_reset", 64'({got, data_out[15:8]}), 64'({1'b1, 8'h5A}));
        rd_en[1] = 1'b1; tick(); rd_en = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
